// File: rtl/lsu_pkg.sv
// Shared codes for the load/store unit: funct3 sizes, memory strobes, FSM states.
// Optional misaligned support is selected in the top by LSU_MISALIGN_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] STRB_W   = 3'b000;
  localparam logic [2:0] STRB_HL  = 3'b001;
  localparam logic [2:0] STRB_NOP = 3'b010;
  localparam logic [2:0] STRB_HH  = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus word-wide memory port of the LSU.
// slave = unit side, master = core/memory side.
interface load_store_unit_if #(
  parameter int DEPTH = 128
) ();

  localparam int AW = $clog2(DEPTH);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_din;
  logic          mem_we;
  logic [2:0]    mem_wr_strb;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_rd_addr, mem_wr_addr,
    output mem_wr_din, mem_we, mem_wr_strb
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_rd_addr, mem_wr_addr,
    input  mem_wr_din, mem_we, mem_wr_strb
  );

endinterface

// File: rtl/load_align.sv
// Load lane select by byte offset, then sign/zero extension by funct3.
// Words pass through unchanged.
module load_align (
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  import lsu_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  // Shift the addressed lane down, then extend.
  always_comb begin
    b = 8'(data >> {off, 3'b000});
    h = 16'(data >> {off, 3'b000});
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'b0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'b0, h};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> ACCESS -> RESP with range/funct3 checks.
// Define LSU_MISALIGN_EN to split misaligned H/W into byte accesses.
module load_store_unit #(
  parameter int DEPTH = 128
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  import lsu_pkg::*;

  localparam int AW = $clog2(DEPTH);
`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  lsu_state_e    state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          take;

  logic [1:0]    sz, last;
  logic          bad_f3, mis, carry;
  logic          oor, err_c, multi;
  logic [AW+1:0] ba;
  logic [7:0]    lane;
  logic [31:0]   acc, al_data, ld_ext;
  logic [1:0]    al_off;

  // Access classification; the end-byte check keeps split accesses in range.
  always_comb begin
    sz     = f3_q[1:0];
    bad_f3 = (sz == 2'b11) || (f3_q[2] && (f3_q[1] || we_q));
    last   = (sz == 2'b10) ? 2'd3 :
             (sz == 2'b01) ? 2'd1 : 2'd0;
    mis    = (sz == 2'b01 && addr_q[0]) ||
             (sz == 2'b10 && addr_q[1:0] != 2'b00);
    carry  = ({1'b0, addr_q[1:0]} + {1'b0, last}) > 3'd3;
    oor    = ({2'b0, addr_q[31:2]} >= 32'(DEPTH)) ||
             ({2'b0, addr_q[31:2]} + 32'(carry) >= 32'(DEPTH));
    err_c  = bad_f3 || oor || (mis && !MIS_EN);
    multi  = mis && MIS_EN;
    ba     = addr_q[AW+1:0] + (AW+2)'(cnt_q);
    lane   = 8'(bus.mem_rd_data >> {ba[1:0], 3'b000});
    acc    = rdata_q | (32'(lane) << {cnt_q, 3'b000});
    al_data = multi ? acc : bus.mem_rd_data;
    al_off  = multi ? 2'b00 : addr_q[1:0];
  end

  assign bus.mem_rd_addr = ba[AW+1:2];
  assign bus.mem_wr_addr = ba[AW+1:2];

  load_align u_align (
    .data   (al_data),
    .off    (al_off),
    .funct3 (f3_q),
    .result (ld_ext)
  );

  // Next state, result and memory/response outputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    take            = 1'b0;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_err    = 1'b0;
    bus.resp_rdata  = '0;
    bus.mem_we      = 1'b0;
    bus.mem_wr_strb = STRB_NOP;
    bus.mem_wr_din  = wdata_q;
    if (rst) begin
      bus.req_ready = 1'b1;
      state_d       = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            take    = 1'b1;
            state_d = ACCESS;
            cnt_d   = 2'd0;
            rdata_d = '0;
            err_d   = 1'b0;
          end
        end
        ACCESS: begin
          state_d = RESP;
          if (err_c) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (multi) begin
            if (we_q) begin
              bus.mem_we      = 1'b1;
              bus.mem_wr_strb = {1'b1, ba[1:0]};
              bus.mem_wr_din  = wdata_q >> {cnt_q, 3'b000};
            end
            if (cnt_q != last) begin
              state_d = ACCESS;
              cnt_d   = cnt_q + 2'd1;
              rdata_d = we_q ? '0 : acc;
            end else begin
              rdata_d = we_q ? '0 : ld_ext;
            end
          end else begin
            if (we_q) begin
              bus.mem_we = 1'b1;
              unique case (1'b1)
                sz == 2'b10: bus.mem_wr_strb = STRB_W;
                sz == 2'b01: bus.mem_wr_strb =
                  addr_q[1] ? STRB_HH : STRB_HL;
                default:     bus.mem_wr_strb =
                  {1'b1, addr_q[1:0]};
              endcase
            end
            rdata_d = we_q ? '0 : ld_ext;
          end
        end
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = err_q;
          bus.resp_rdata = rdata_q;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and captured request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= F3_W;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (take) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a strobe-decoding memory model.
// Misaligned expectations follow LSU_MISALIGN_EN.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  load_store_unit_if #(.DEPTH(128)) bus ();

  load_store_unit #(.DEPTH(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [128];
  logic [2:0]  wstrb [256];
  logic [6:0]  waddr [256];
  int          wcnt;

  assign bus.mem_rd_data = mem[bus.mem_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: decodes the strobe code and logs every write.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      case (bus.mem_wr_strb)
        3'b000: mem[bus.mem_wr_addr] <= bus.mem_wr_din;
        3'b001: mem[bus.mem_wr_addr][15:0] <= bus.mem_wr_din[15:0];
        3'b011: mem[bus.mem_wr_addr][31:16] <= bus.mem_wr_din[15:0];
        3'b010: ;
        default:
          mem[bus.mem_wr_addr][{bus.mem_wr_strb[1:0], 3'b000} +: 8]
            <= bus.mem_wr_din[7:0];
      endcase
      wstrb[wcnt[7:0]] <= bus.mem_wr_strb;
      waddr[wcnt[7:0]] <= bus.mem_wr_addr;
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int edges);
    int k;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    k = 0;
    while (!bus.req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    edges = 1;
    while (!bus.resp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          ed;
  int          base;
  int          seen;

  initial begin
    errors = 0;
    checks = 0;
    wcnt   = 0;
    rst    = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_strb", 32'(bus.mem_wr_strb), 32'd2);
    @(negedge clk);
    rst = 1'b0;

    base = wcnt;
    xfer(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, rd, er, ed);
    chk("sw_edges", 32'(ed), 32'd2);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_nwr", 32'(wcnt - base), 32'd1);
    chk("sw_strb", 32'(wstrb[base]), 32'd0);
    chk("sw_waddr", 32'(waddr[base]), 32'd2);
    chk("sw_mem", mem[2], 32'hDEADBEEF);
    base = wcnt;
    xfer(1'b0, 3'b010, 32'h8, 32'h0, rd, er, ed);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_edges", 32'(ed), 32'd2);
    chk("lw_nwr", 32'(wcnt - base), 32'd0);

    xfer(1'b1, 3'b010, 32'h4, 32'h11223344, rd, er, ed);
    base = wcnt;
    xfer(1'b1, 3'b000, 32'h6, 32'h000000F0, rd, er, ed);
    chk("sb_strb", 32'(wstrb[base]), 32'd6);
    chk("sb_mem", mem[1], 32'h11F03344);
    xfer(1'b0, 3'b000, 32'h6, 32'h0, rd, er, ed);
    chk("lb_rdata", rd, 32'hFFFFFFF0);
    xfer(1'b0, 3'b100, 32'h6, 32'h0, rd, er, ed);
    chk("lbu_rdata", rd, 32'h000000F0);

    xfer(1'b1, 3'b010, 32'h0, 32'hAABBCCDD, rd, er, ed);
    base = wcnt;
    xfer(1'b1, 3'b001, 32'h2, 32'h00008001, rd, er, ed);
    chk("sh_strb", 32'(wstrb[base]), 32'd3);
    chk("sh_mem", mem[0], 32'h8001CCDD);
    xfer(1'b0, 3'b001, 32'h2, 32'h0, rd, er, ed);
    chk("lh_rdata", rd, 32'hFFFF8001);
    xfer(1'b0, 3'b101, 32'h2, 32'h0, rd, er, ed);
    chk("lhu_rdata", rd, 32'h00008001);
    xfer(1'b0, 3'b000, 32'h0, 32'h0, rd, er, ed);
    chk("lb0_rdata", rd, 32'hFFFFFFDD);
    base = wcnt;
    xfer(1'b1, 3'b001, 32'h0, 32'hFFFF1234, rd, er, ed);
    chk("shl_strb", 32'(wstrb[base]), 32'd1);
    chk("shl_mem", mem[0], 32'h80011234);

    base = wcnt;
    xfer(1'b0, 3'b010, 32'h201, 32'h0, rd, er, ed);
    chk("oor1_err", 32'(er), 32'd1);
    chk("oor1_rdata", rd, 32'd0);
    chk("oor1_edges", 32'(ed), 32'd2);
    xfer(1'b0, 3'b010, 32'h200, 32'h0, rd, er, ed);
    chk("oor2_err", 32'(er), 32'd1);
    xfer(1'b1, 3'b010, 32'h200, 32'h12345678, rd, er, ed);
    chk("oor3_err", 32'(er), 32'd1);
    xfer(1'b0, 3'b011, 32'h0, 32'h0, rd, er, ed);
    chk("f3bad_err", 32'(er), 32'd1);
    xfer(1'b1, 3'b100, 32'h0, 32'h55, rd, er, ed);
    chk("sbu_err", 32'(er), 32'd1);
    chk("err_nwr", 32'(wcnt - base), 32'd0);
    chk("err_mem0", mem[0], 32'h80011234);
    xfer(1'b1, 3'b010, 32'h1FC, 32'h5A5A5A5A, rd, er, ed);
    chk("top_sw_err", 32'(er), 32'd0);
    xfer(1'b0, 3'b010, 32'h1FC, 32'h0, rd, er, ed);
    chk("top_lw", rd, 32'h5A5A5A5A);

    xfer(1'b1, 3'b010, 32'h0, 32'h00000000, rd, er, ed);
    xfer(1'b1, 3'b010, 32'h4, 32'hFFFFFFFF, rd, er, ed);
    base = wcnt;
    xfer(1'b1, 3'b010, 32'h3, 32'h11223344, rd, er, ed);
`ifdef LSU_MISALIGN_EN
    chk("msw_err", 32'(er), 32'd0);
    chk("msw_edges", 32'(ed), 32'd5);
    chk("msw_nwr", 32'(wcnt - base), 32'd4);
    chk("msw_s0", {25'd0, wstrb[base], waddr[base]}, {25'd0, 3'd7, 7'd0});
    chk("msw_s1", {25'd0, wstrb[base+1], waddr[base+1]}, {25'd0, 3'd4, 7'd1});
    chk("msw_s2", {25'd0, wstrb[base+2], waddr[base+2]}, {25'd0, 3'd5, 7'd1});
    chk("msw_s3", {25'd0, wstrb[base+3], waddr[base+3]}, {25'd0, 3'd6, 7'd1});
    chk("msw_mem0", mem[0], 32'h44000000);
    chk("msw_mem1", mem[1], 32'hFF112233);
    xfer(1'b0, 3'b010, 32'h3, 32'h0, rd, er, ed);
    chk("mlw_rdata", rd, 32'h11223344);
    chk("mlw_edges", 32'(ed), 32'd5);
    xfer(1'b0, 3'b001, 32'h3, 32'h0, rd, er, ed);
    chk("mlh_rdata", rd, 32'h00003344);
    chk("mlh_edges", 32'(ed), 32'd3);
`else
    chk("msw_err", 32'(er), 32'd1);
    chk("msw_edges", 32'(ed), 32'd2);
    chk("msw_nwr", 32'(wcnt - base), 32'd0);
    chk("msw_mem0", mem[0], 32'h00000000);
    chk("msw_mem1", mem[1], 32'hFFFFFFFF);
    xfer(1'b0, 3'b001, 32'h3, 32'h0, rd, er, ed);
    chk("mlh_err", 32'(er), 32'd1);
`endif

    xfer(1'b1, 3'b010, 32'h0, 32'h00000000, rd, er, ed);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
`ifdef LSU_MISALIGN_EN
    bus.req_addr   = 32'h3;
`else
    bus.req_addr   = 32'h8;
`endif
    bus.req_wdata  = 32'hA5B6C7D8;
    while (!bus.req_ready) @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
    @(posedge clk);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1;
    chk("mrst_ready", 32'(bus.req_ready), 32'd1);
    chk("mrst_rvalid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen++;
    end
    chk("mrst_noresp", 32'(seen), 32'd0);
`ifdef LSU_MISALIGN_EN
    chk("mrst_mem0", mem[0], 32'hD8000000);
    chk("mrst_mem1", mem[1], 32'hFF112233);
`else
    chk("mrst_mem2", mem[2], 32'hDEADBEEF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  core presents an access.
REQ-005 SHALL have port req_ready  output  1  unit accepts an access; high only in IDLE.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  access rejected; valid with resp_valid.
REQ-013 SHALL have port mem_rd_addr  output  clog2(DEPTH)  word index to memory async read port.
REQ-014 SHALL have port mem_rd_data  input  32  memory async read data.
REQ-015 SHALL have port mem_wr_addr  output  clog2(DEPTH)  word index to memory write port.
REQ-016 SHALL have port mem_wr_din  output  32  write data, lane placed at bit 0 (byte) or bit 0 (half).
REQ-017 SHALL have port mem_we  output  1  write enable.
REQ-018 SHALL have port mem_wr_strb  output  3  memory strobe code: 000 word, 001 low half, 010 nop, 011 high half, 100..111 byte 0..3.

Function
REQ-019 SHALL implement states IDLE, ACCESS, RESP; handshake completes on edge where req_valid and req_ready both high, capturing all req_* fields.
REQ-020 SHALL, for an aligned access, spend exactly one cycle in ACCESS, then one cycle in RESP (resp_valid=1), then IDLE: resp_valid two edges after acceptance.
REQ-021 SHALL in ACCESS for a store drive mem_we=1 with word index addr[clog2(DEPTH)+1:2] and strb: SW 000; SH 001 (addr[1]=0) or 011 (addr[1]=1); SB 1,addr[1:0].
REQ-022 SHALL in ACCESS for a load capture mem_rd_data, select byte/half by addr[1:0], sign-extend for B/H, zero-extend for BU/HU.
REQ-023 SHALL hold mem_we=0 and mem_wr_strb=010 in every cycle outside a store ACCESS cycle.
REQ-024 SHALL flag resp_err (no memory write, resp_rdata=0, one ACCESS cycle) for: invalid funct3 (011,110,111; 100/101 with store), or addr[31:2] >= DEPTH.
REQ-025 SHALL ignore req_* while not in IDLE; back-to-back requests accepted earliest in the IDLE cycle following RESP.

Reset
REQ-026 SHALL on rst=1 force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_wr_strb=010, byte counter 0, regardless of state.
REQ-027 SHALL, on reset mid misaligned store, leave already-written bytes in memory and issue no response.

Configuration
REQ-028 SHALL support macro LSU_MISALIGN_EN.
REQ-029 SHALL with LSU_MISALIGN_EN decompose misaligned H/W accesses into per-byte ACCESS cycles, ascending address, one byte per cycle (H: 2 cycles, W: 4), assembling load bytes little-endian; out-of-range check applies to every byte.
REQ-030 SHALL without LSU_MISALIGN_EN treat misaligned H/W accesses as resp_err per REQ-024.

Structure
REQ-031 SHALL place funct3 codes, mem strobe codes, and state encoding in shared package lsu_pkg.
REQ-032 SHALL use one sub-module load_align: combinational lane select plus sign/zero extension.

Verification
REQ-033 SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> mem_wr_strb 000, word 2 written; resp_rdata 0xDEADBEEF two edges after acceptance.
REQ-034 SB addr 0x6 data 0x000000F0, then LB 0x6 and LBU 0x6 -> strb 110; results 0xFFFFFFF0 and 0x000000F0; other bytes of word 1 unchanged.
REQ-035 SH addr 0x2 data 0x8001, LH 0x2 -> strb 011; result 0xFFFF8001.
REQ-036 LW addr 0x201 (DEPTH=128) -> resp_err=1, resp_rdata=0, mem_we never high; LW addr 0x200 -> resp_err=1.
REQ-037 SW addr 0x3 data 0x11223344: with macro -> four byte writes (strb 111 word 0, then 100,101,110 word 1), LW 0x3 returns 0x11223344, resp after 5 edges; without macro -> resp_err=1, memory unchanged.
REQ-038 rst asserted during second byte cycle of misaligned SW -> next edge IDLE, req_ready=1, no resp_valid, first byte retained.
